// File: rtl/lm32_addsub_pipe.sv
// lm32_addsub_pipe: pipelined two's-complement adder/subtractor, one carry slice per stage
module lm32_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             kill_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_a_i,
  input  logic [WIDTH-1:0] data_b_i,
  input  logic             cin_i,
  input  logic             add_sub_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             valid_o
);
  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];
  logic [WIDTH-1:0]  a_x [STAGES];
  logic [WIDTH-1:0]  b_x [STAGES];
  logic [WIDTH-1:0]  r_x [STAGES];
  logic [WIDTH-1:0]  r_d [STAGES];
  logic [STAGES-1:0] c_q, c_d, v_q, v_d;
  logic [SW:0]       s;
  logic              c_x, ovf_d, ovf_q, zero_d, zero_q;
  int                p;
  // stage k consumes the registers of stage k-1; stage 0 consumes the ports
  always_comb begin
    s     = '0;
    c_x   = 1'b0;
    p     = 0;
    for (int k = 0; k < STAGES; k++) begin
      p        = (k == 0) ? 0 : k - 1;
      a_x[k]   = (k == 0) ? data_a_i : a_q[p];
      b_x[k]   = (k == 0) ? (add_sub_i ? data_b_i : ~data_b_i) : b_q[p];
      r_x[k]   = (k == 0) ? '0 : r_q[p];
      c_x      = (k == 0) ? cin_i : c_q[p];
      v_d[k]   = (k == 0) ? valid_i : v_q[p];
      s        = {1'b0, a_x[k][k*SW +: SW]} + {1'b0, b_x[k][k*SW +: SW]} + {{SW{1'b0}}, c_x};
      r_d[k]   = r_x[k];
      r_d[k][k*SW +: SW] = s[SW-1:0];
      c_d[k]   = s[SW];
    end
    ovf_d  = a_x[L][WIDTH-1] ^ b_x[L][WIDTH-1] ^ r_d[L][WIDTH-1] ^ c_d[L];
    zero_d = ~|r_d[L];
  end
  // kill wins over stall for the valid bits only; data follows stall alone
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
      c_q    <= '0;
      v_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      v_q <= kill_i ? '0 : stall_i ? v_q : v_d;
      if (!stall_i) begin
        for (int k = 0; k < STAGES; k++) begin
          a_q[k] <= a_x[k];
          b_q[k] <= b_x[k];
          r_q[k] <= r_d[k];
        end
        c_q    <= c_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end
  assign result_o = r_q[L];
  assign cout_o   = c_q[L];
  assign ovf_o    = ovf_q;
  assign zero_o   = zero_q;
  assign valid_o  = v_q[L];
endmodule
